// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order {pc, inst} buffer between fetch and decode with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [PC_W-1:0]          if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [PC_W-1:0]          id_pc,
    output logic [INST_W-1:0]        id_inst,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = PC_W + INST_W;
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [c_DW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_push;
    logic            w_pop;
    logic [c_DW-1:0] w_head;

    // Readiness depends on occupancy only, so a full queue never accepts
    // even when decode is draining in the same cycle.
    assign if_ready = (r_count != c_FULL);
    assign id_valid = (r_count != '0);
    assign count    = r_count;

    assign w_push = if_valid & if_ready & ~flush;
    assign w_pop  = id_valid & id_ready & ~flush;

    assign w_head  = r_mem[r_rd_ptr];
    assign id_pc   = id_valid ? w_head[c_DW-1:INST_W] : '0;
    assign id_inst = id_valid ? w_head[INST_W-1:0]    : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {if_pc, if_inst};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Scoreboard bench for fetch_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_ready;
    logic [$clog2(DEPTH):0] count;

    int checks;
    int failures;

    logic [63:0] r_exp_q [$];

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted {pc, inst} pairs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_q.delete();
        end else if (flush) begin
            r_exp_q.delete();
        end else begin
            logic can_push;
            can_push = if_valid && (r_exp_q.size() < DEPTH);
            if (id_ready && r_exp_q.size() > 0) begin
                void'(r_exp_q.pop_front());
            end
            if (can_push) begin
                r_exp_q.push_back({if_pc, if_inst});
            end
        end
    end

    // Monitor: compares what decode sees against the model head.
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(r_exp_q.size()));
        chk("id_valid", 64'(id_valid), 64'(r_exp_q.size() != 0));
        chk("if_ready", 64'(if_ready), 64'(r_exp_q.size() != DEPTH));
        if (r_exp_q.size() != 0) begin
            chk("head_pc", 64'(id_pc), 64'(r_exp_q[0][63:32]));
            chk("head_inst", 64'(id_inst), 64'(r_exp_q[0][31:0]));
        end else begin
            chk("idle_pc", 64'(id_pc), 64'h0);
            chk("idle_inst", 64'(id_inst), 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = ~pc;
    endtask

    task automatic drain();
        if_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (r_exp_q.size() == 0) break;
            tick();
        end
        id_ready = 1'b0;
        chk("drain_count", 64'(count), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        logic        acc;
        int          n;
        int          guard;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        #12;
        chk("rst_id_valid", 64'(id_valid), 64'h0);
        chk("rst_id_pc", 64'(id_pc), 64'h0);
        chk("rst_if_ready", 64'(if_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // Fill with decode stalled, then a fifth offer that must be refused
        for (int i = 0; i < 4; i++) begin
            present(32'(i * 4));
            tick();
        end
        present(32'h10);
        tick();
        chk("fill_count", 64'(count), 64'h4);
        chk("fill_if_ready", 64'(if_ready), 64'h0);
        chk("fill_head", 64'(id_pc), 64'h0);
        if_valid = 1'b0;
        id_ready = 1'b1;
        repeat (4) tick();
        id_ready = 1'b0;
        chk("fill_drained", 64'(count), 64'h0);

        // Concurrent push and pop at occupancy two
        present(32'h20); tick();
        present(32'h24); tick();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(32'h28 + 32'(i * 4));
            tick();
        end
        chk("conc_count", 64'(count), 64'h2);
        chk("conc_head", 64'(id_pc), 64'h2c);
        drain();

        // Flush while full with a concurrent offer
        for (int i = 0; i < 4; i++) begin
            present(32'h50 + 32'(i * 4));
            tick();
        end
        present(32'h40);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_id_valid", 64'(id_valid), 64'h0);
        chk("flush_if_ready", 64'(if_ready), 64'h1);
        present(32'h80);
        tick();
        if_valid = 1'b0;
        chk("flush_next_head", 64'(id_pc), 64'h80);
        drain();

        // Ten-entry stream with alternating decode readiness; fetch holds on refusal
        n = 0;
        guard = 0;
        while (n < 10 && guard < 200) begin
            present(32'(n * 4));
            id_ready = guard[0];
            @(negedge clk);
            acc = if_valid && if_ready && !flush;
            tick();
            if (acc) n++;
            guard++;
        end
        chk("wrap_sent", 64'(n), 64'd10);
        drain();

        // Empty latency: no same-cycle bypass
        present(32'h100);
        #2;
        chk("lat_same_cycle", 64'(id_valid), 64'h0);
        tick();
        if_valid = 1'b0;
        chk("lat_next_valid", 64'(id_valid), 64'h1);
        chk("lat_next_pc", 64'(id_pc), 64'h100);
        drain();

        // Asynchronous reset between edges with three entries held
        for (int i = 0; i < 3; i++) begin
            present(32'h180 + 32'(i * 4));
            tick();
        end
        if_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_id_valid", 64'(id_valid), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        tick();
        reset = 1'b0;
        chk("arst_if_ready", 64'(if_ready), 64'h1);
        present(32'h200); tick();
        present(32'h204); tick();
        if_valid = 1'b0;
        chk("arst_first_pc", 64'(id_pc), 64'h200);
        drain();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            pc       = $urandom;
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc    = {pc[31:2], 2'b00};
            if_inst  = $urandom;
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
